// File: rtl/csm_nport_if.sv
// Bundle of per-port command and response signals for the N-port shared-memory controller.
// The lock-release strobe is named release_lock because "release" is a reserved word.
interface csm_nport_if #(
  parameter int NPORTS = 4,
  parameter int DATA_W = 8
);
  logic [NPORTS*DATA_W-1:0] in_ad;
  logic [NPORTS-1:0]        rw;
  logic [NPORTS-1:0]        enable;
  logic [NPORTS-1:0]        hold;
  logic [NPORTS-1:0]        release_lock;
  logic [NPORTS-1:0]        ack;
  logic [NPORTS*DATA_W-1:0] out_data;
  logic [NPORTS*2-1:0]      err;

  modport master (
    output in_ad, rw, enable, hold, release_lock,
    input  ack, out_data, err
  );

  modport slave (
    input  in_ad, rw, enable, hold, release_lock,
    output ack, out_data, err
  );
endinterface

// File: rtl/csm_nport.sv
// Lock-based N-port shared-memory controller: round-robin lock grant, muxed address/data
// reads and writes by the lock owner, and an idle-hold watchdog that reclaims the lock.
module csm_nport #(
  parameter int NPORTS       = 4,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int HOLD_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  csm_nport_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PORT_W = $clog2(NPORTS);
  localparam int CNT_W  = $clog2(HOLD_TIMEOUT + 2);

  generate
    if (ADDR_W > DATA_W || NPORTS < 2 || NPORTS > 8) begin : g_bad_params
      $error("csm_nport: illegal parameters (need 2<=NPORTS<=8 and clog2(DEPTH)<=DATA_W)");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, GRANT, WDATA} state_t;

  state_t              state;
  logic [PORT_W-1:0]   owner;
  logic [PORT_W-1:0]   rr_ptr;
  logic [PORT_W-1:0]   pick;
  logic [PORT_W-1:0]   idx;
  logic                pick_valid;
  logic [CNT_W-1:0]    wd_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   mem   [DEPTH];
  logic [DATA_W-1:0]   ad    [NPORTS];
  logic [DATA_W-1:0]   rdata [NPORTS];
  logic [NPORTS-1:0]   ack_set;
  logic [NPORTS-1:0]   ack_q;
  logic [1:0]          err_next [NPORTS];
  logic [1:0]          err_q    [NPORTS];
  logic                own_en;
  logic                own_rel;
  logic                evict;
  logic                is_owner;

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign ad[i]                            = bus.in_ad[i*DATA_W +: DATA_W];
    assign bus.out_data[i*DATA_W +: DATA_W] = rdata[i];
    assign bus.err[2*i +: 2]                = err_q[i];
  end
  assign bus.ack = ack_q;

  // Round-robin search: walk from the port after rr_ptr, wrapping, first holder wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = rr_ptr;
    idx        = rr_ptr;
    for (int k = 0; k < NPORTS; k++) begin
      idx = (idx == PORT_W'(NPORTS - 1)) ? '0 : idx + PORT_W'(1);
      if (!pick_valid && bus.hold[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  // An error on a port masks that port's ack in the same cycle; the access itself still
  // takes effect, so ack and err never coincide.
  always_comb begin
    own_en   = bus.enable[owner];
    own_rel  = bus.release_lock[owner];
    evict    = (HOLD_TIMEOUT != 0) && (state == GRANT) && !own_en && !own_rel &&
               (wd_cnt == CNT_W'(HOLD_TIMEOUT - 1));
    ack_set  = '0;
    is_owner = 1'b0;
    case (state)
      IDLE:    if (pick_valid) ack_set[pick] = 1'b1;
      GRANT:   if (own_en && bus.rw[owner]) ack_set[owner] = 1'b1;
      WDATA:   ack_set[owner] = 1'b1;
      default: ;
    endcase
    for (int i = 0; i < NPORTS; i++) begin
      is_owner    = (state != IDLE) && (owner == PORT_W'(i));
      err_next[i] = 2'b00;
      if (bus.enable[i] && !is_owner)
        err_next[i] = 2'b01;
      if (bus.release_lock[i] && (!is_owner || state == WDATA || bus.enable[i]))
        err_next[i] = 2'b11;
      if (evict && is_owner)
        err_next[i] = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= PORT_W'(NPORTS - 1);
      wd_cnt  <= '0;
      wr_addr <= '0;
      ack_q   <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        err_q[i] <= 2'b00;
        rdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        err_q[i] <= err_next[i];
        ack_q[i] <= ack_set[i] && (err_next[i] == 2'b00);
      end
      case (state)
        IDLE: begin
          if (pick_valid) begin
            owner  <= pick;
            rr_ptr <= pick;
            wd_cnt <= '0;
            state  <= GRANT;
          end
        end
        GRANT: begin
          if (own_en) begin
            wd_cnt <= '0;
            if (bus.rw[owner]) begin
              rdata[owner] <= mem[ad[owner][ADDR_W-1:0]];
            end else begin
              wr_addr <= ad[owner][ADDR_W-1:0];
              state   <= WDATA;
            end
          end else if (own_rel || evict) begin
            state <= IDLE;
          end else if (HOLD_TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        WDATA:   state <= GRANT;
        default: state <= IDLE;
      endcase
    end
  end

  // The array has no reset; an async reset during WDATA leaves state IDLE so no write lands.
  always_ff @(posedge clk) begin
    if (state == WDATA)
      mem[wr_addr] <= ad[owner];
  end
endmodule

// File: tb/tb_csm_nport.sv
// Randomised and directed bench for csm_nport, checked cycle by cycle against a
// transaction-level model of the lock, round-robin, memory and watchdog rules.
module tb_csm_nport;
  localparam int NPORTS       = 4;
  localparam int DATA_W       = 8;
  localparam int DEPTH        = 16;
  localparam int HOLD_TIMEOUT = 32;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  csm_nport_if #(.NPORTS(NPORTS), .DATA_W(DATA_W)) bus ();

  csm_nport #(
    .NPORTS(NPORTS), .DATA_W(DATA_W), .DEPTH(DEPTH), .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_owner;
  int         m_wr_addr;
  int         m_idle;
  int         m_rr;
  bit         m_granted;
  logic [7:0] m_mem [DEPTH];
  logic [7:0] m_out [NPORTS];
  logic [3:0] exp_ack;
  logic [7:0] exp_err;
  logic [7:0] pre_val [DEPTH];
  int         exp_order [4] = '{0, 1, 3, 0};
  int         order [$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] put(input int port, input logic [7:0] v);
    return 32'(v) << (port * 8);
  endfunction

  function automatic logic [31:0] exp_out();
    logic [31:0] r;
    for (int p = 0; p < NPORTS; p++) r[p*8 +: 8] = m_out[p];
    return r;
  endfunction

  task automatic modelReset();
    m_owner   = -1;
    m_wr_addr = -1;
    m_idle    = 0;
    m_rr      = NPORTS - 1;
    exp_ack   = '0;
    exp_err   = '0;
    for (int p = 0; p < NPORTS; p++) m_out[p] = 8'h00;
  endtask

  // Owner -1 means nobody holds the lock; m_wr_addr >= 0 means the owner is in its data phase.
  task automatic modelStep(input logic [3:0] en, input logic [3:0] r, input logic [3:0] h,
                           input logic [3:0] rl, input logic [31:0] ad);
    int         e [NPORTS];
    logic [3:0] a;
    int         o, q;
    bit         writing;
    a         = '0;
    m_granted = 0;
    writing   = (m_wr_addr >= 0);
    for (int p = 0; p < NPORTS; p++) begin
      e[p] = 0;
      if (en[p] && m_owner != p) e[p] = 1;
      if (rl[p] && (m_owner != p || writing || en[p])) e[p] = 3;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= NPORTS; k++) begin
        q = (m_rr + k) % NPORTS;
        if (h[q]) begin
          a[q] = 1'b1; m_owner = q; m_rr = q; m_idle = 0; m_granted = 1;
          break;
        end
      end
    end else if (writing) begin
      m_mem[m_wr_addr] = ad[m_owner*8 +: 8];
      a[m_owner]       = 1'b1;
      m_wr_addr        = -1;
    end else begin
      o = m_owner;
      if (en[o]) begin
        m_idle = 0;
        if (r[o]) begin
          m_out[o] = m_mem[ad[o*8 +: 8] % DEPTH];
          a[o]     = 1'b1;
        end else begin
          m_wr_addr = ad[o*8 +: 8] % DEPTH;
        end
      end else if (rl[o]) begin
        m_owner = -1;
      end else begin
        m_idle++;
        if (HOLD_TIMEOUT != 0 && m_idle == HOLD_TIMEOUT) begin
          e[o]    = 2;
          m_owner = -1;
        end
      end
    end
    for (int p = 0; p < NPORTS; p++) begin
      if (e[p] != 0) a[p] = 1'b0;
      exp_err[p*2 +: 2] = 2'(e[p]);
    end
    exp_ack = a;
  endtask

  task automatic applyStimulus(input logic [3:0] en, input logic [3:0] r, input logic [3:0] h,
                               input logic [3:0] rl, input logic [31:0] ad);
    bus.enable       = en;
    bus.rw           = r;
    bus.hold         = h;
    bus.release_lock = rl;
    bus.in_ad        = ad;
    modelStep(en, r, h, rl, ad);
    @(posedge clk);
    #1;
    checkOutput("ack", 32'(bus.ack), 32'(exp_ack));
    checkOutput("err", 32'(bus.err), 32'(exp_err));
    checkOutput("out_data", bus.out_data, exp_out());
    @(negedge clk);
  endtask

  task automatic doReset();
    bus.enable       = '0;
    bus.rw           = '0;
    bus.hold         = '0;
    bus.release_lock = '0;
    bus.in_ad        = '0;
    reset_n          = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_ack", 32'(bus.ack), 32'h0);
    checkOutput("rst_err", 32'(bus.err), 32'h0);
    checkOutput("rst_out_data", bus.out_data, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] en, rl, h;
    int         obs, o;
    bit         accessed;

    #2;
    doReset();

    // Give every word a known value through port 0.
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 32'h0);
    for (int a = 0; a < DEPTH; a++) begin
      pre_val[a] = 8'($urandom);
      applyStimulus(4'b0001, 4'b0000, 4'b0001, 4'b0000, put(0, 8'(a)));
      applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, put(0, pre_val[a]));
    end
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0000, 32'h0);

    // Scenario: first grant goes to port 0, then a read of address 3.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0001, 4'b0000, 32'h0);
    checkOutput("t1_grant_ack", 32'(bus.ack), 32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 4'b0000, put(0, 8'd3));
    checkOutput("t1_read_ack", 32'(bus.ack), 32'h1);
    checkOutput("t1_read_data", 32'(bus.out_data[7:0]), 32'(pre_val[3]));
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 4'b0001, 32'h0);

    // Scenario: port 2 writes 0xA5 to 5, reads it back directly and through the wrapped address.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0100, 4'b0000, 32'h0);
    applyStimulus(4'b0100, 4'b0000, 4'b0100, 4'b0000, put(2, 8'h05));
    checkOutput("t2_no_early_ack", 32'(bus.ack), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0100, 4'b0000, put(2, 8'hA5));
    checkOutput("t2_write_ack", 32'(bus.ack), 32'h4);
    pre_val[5] = 8'hA5;
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0000, put(2, 8'h05));
    checkOutput("t2_read", 32'(bus.out_data[23:16]), 32'hA5);
    applyStimulus(4'b0100, 4'b0100, 4'b0100, 4'b0000, put(2, 8'h15));
    checkOutput("t2_read_wrap", 32'(bus.out_data[23:16]), 32'hA5);

    // Scenario: ports 0,1,3 keep holding; each releases after one read.
    doReset();
    accessed = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      en = '0; rl = '0;
      o  = m_owner;
      if (o >= 0) begin
        if (!accessed) begin en[o] = 1'b1; accessed = 1; end
        else begin rl[o] = 1'b1; accessed = 0; end
      end
      applyStimulus(en, 4'b1111, 4'b1011, rl, $urandom);
      if (m_granted) begin
        obs = -1;
        for (int i = 0; i < NPORTS; i++) if (bus.ack[i]) obs = i;
        order.push_back(obs);
      end
    end
    checkOutput("t3_grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++)
      checkOutput("t3_grant_order", 32'(order[i]), 32'(exp_order[i]));

    // Scenario: a non-owner's enable is rejected and leaves memory alone.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h0);
    applyStimulus(4'b0100, 4'b0000, 4'b0010, 4'b0000, put(2, 8'h05));
    checkOutput("t4_err_nonowner", 32'(bus.err[5:4]), 32'h1);
    checkOutput("t4_no_ack", 32'(bus.ack), 32'h0);
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, put(2, 8'h3C));
    applyStimulus(4'b0010, 4'b0010, 4'b0010, 4'b0000, put(1, 8'h05));
    checkOutput("t4_still_owner", 32'(bus.ack), 32'h2);
    checkOutput("t4_mem_kept", 32'(bus.out_data[15:8]), 32'hA5);

    // Scenario: watchdog evicts an idle port 0, then the waiting port 1 is granted.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0011, 4'b0000, 32'h0);
    checkOutput("t5_grant0", 32'(bus.ack), 32'h1);
    repeat (HOLD_TIMEOUT) applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h0);
    checkOutput("t5_evict_err", 32'(bus.err[1:0]), 32'h2);
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h0);
    checkOutput("t5_next_grant", 32'(bus.ack), 32'h2);

    // Scenario: reset lands in the write-data cycle, so the write must be lost.
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0010, 4'b0000, 32'h0);
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 4'b0000, put(1, 8'h07));
    bus.in_ad = put(1, ~pre_val[7]);
    #2;
    doReset();
    applyStimulus(4'b0000, 4'b0000, 4'b0011, 4'b0000, 32'h0);
    checkOutput("t6_grant0", 32'(bus.ack), 32'h1);
    applyStimulus(4'b0001, 4'b0001, 4'b0011, 4'b0000, put(0, 8'h07));
    checkOutput("t6_no_write", 32'(bus.out_data[7:0]), 32'(pre_val[7]));

    // Random traffic mixing owner accesses, releases, and stray non-owner strobes.
    for (int c = 0; c < 600; c++) begin
      h  = 4'($urandom);
      en = '0; rl = '0;
      o  = m_owner;
      if (o >= 0 && m_wr_addr < 0) begin
        case ($urandom % 8)
          0, 1, 2, 3: en[o] = 1'b1;
          4:          rl[o] = 1'b1;
          5:          begin en[o] = 1'b1; rl[o] = 1'b1; end
          default:    ;
        endcase
      end else if (o >= 0 && ($urandom % 8) == 0) begin
        rl[o] = 1'b1;
      end
      if (($urandom % 12) == 0) en[$urandom % NPORTS] = 1'b1;
      if (($urandom % 16) == 0) rl[$urandom % NPORTS] = 1'b1;
      applyStimulus(en, 4'($urandom), h, rl, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
